// File: rtl/temp_calc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | temp_calc_pkg : shared types and width helpers for temp_calc_seq   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package temp_calc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ADD  = 2'd2,
    OUT  = 2'd3
  } state_t;

  localparam int c_DEF_CHANNELS   = 4;
  localparam int c_DEF_CH_W       = 2;
  localparam int c_DEF_BASE_W     = 8;
  localparam int c_DEF_COEF_W     = 4;
  localparam int c_DEF_SENS_W     = 4;
  localparam int c_DEF_FRAC_SHIFT = 3;

  function automatic int prodWidth(input int coefW, input int sensW);
    return coefW + sensW;
  endfunction

endpackage
`default_nettype wire

// File: rtl/temp_calc_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | temp_calc_if : calibration, sample and result channels             |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface temp_calc_if
  import temp_calc_pkg::*;
#(
  parameter int CH_W   = c_DEF_CH_W,
  parameter int BASE_W = c_DEF_BASE_W,
  parameter int COEF_W = c_DEF_COEF_W,
  parameter int SENS_W = c_DEF_SENS_W
);
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [BASE_W-1:0] cfg_base;
  logic [COEF_W-1:0] cfg_coef;

  logic              in_valid;
  logic              in_ready;
  logic [CH_W-1:0]   in_ch;
  logic [SENS_W-1:0] in_sensor;

  logic              out_valid;
  logic              out_ready;
  logic [CH_W-1:0]   out_ch;
  logic [BASE_W-1:0] out_temp;
  logic              out_ovf;
  logic              out_err;

  modport master (
    output cfg_we, cfg_ch, cfg_base, cfg_coef,
    output in_valid, in_ch, in_sensor,
    input  in_ready,
    input  out_valid, out_ch, out_temp, out_ovf, out_err,
    output out_ready
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_base, cfg_coef,
    input  in_valid, in_ch, in_sensor,
    output in_ready,
    output out_valid, out_ch, out_temp, out_ovf, out_err,
    input  out_ready
  );
endinterface
`default_nettype wire

// File: rtl/shift_add_mul.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | shift_add_mul : LSB-first sequential shift-add multiplier          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module shift_add_mul
  import temp_calc_pkg::*;
#(
  parameter int COEF_W = c_DEF_COEF_W,
  parameter int SENS_W = c_DEF_SENS_W,
  localparam int PROD_W = prodWidth(COEF_W, SENS_W)
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              start,
  input  wire logic [COEF_W-1:0] multiplicand,
  input  wire logic [SENS_W-1:0] multiplier,
  output logic                   done,
  output logic [PROD_W-1:0]      product
);
  localparam int CNT_W = $clog2(SENS_W + 1);
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(SENS_W - 1);

  logic [PROD_W-1:0] r_prod;
  logic [PROD_W-1:0] r_mcand;
  logic [SENS_W-1:0] r_mplier;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy;
  logic              w_last;

  assign w_last  = (r_cnt == c_LAST);
  // done marks the edge that performs the final step, so the product is
  // complete in the cycle after it.
  assign done    = r_busy && w_last;
  assign product = r_prod;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prod   <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (start) begin
      r_prod   <= '0;
      r_mcand  <= PROD_W'(multiplicand);
      r_mplier <= multiplier;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      if (r_mplier[0]) begin
        r_prod <= r_prod + r_mcand;
      end
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
      if (w_last) begin
        r_busy <= 1'b0;
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/temp_calc_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | temp_calc_seq : multi-channel calibrated temperature, saturating   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module temp_calc_seq
  import temp_calc_pkg::*;
#(
  parameter int unsigned CHANNELS   = c_DEF_CHANNELS,
  parameter int          CH_W       = c_DEF_CH_W,
  parameter int          BASE_W     = c_DEF_BASE_W,
  parameter int          COEF_W     = c_DEF_COEF_W,
  parameter int          SENS_W     = c_DEF_SENS_W,
  parameter int          FRAC_SHIFT = c_DEF_FRAC_SHIFT
) (
  input wire logic   clk,
  input wire logic   rst,
  temp_calc_if.slave bus
);
  localparam int PROD_W = prodWidth(COEF_W, SENS_W);
  localparam int SUM_W  = ((BASE_W > PROD_W) ? BASE_W : PROD_W) + 1;

  logic [BASE_W-1:0] r_calBase [CHANNELS];
  logic [COEF_W-1:0] r_calCoef [CHANNELS];

  state_t            r_state;
  state_t            w_stateNext;
  logic              w_inReady, w_accept, w_load, w_pop;

  logic [CH_W-1:0]   r_ch;
  logic [BASE_W-1:0] r_base;
  logic              r_err;
  logic              r_outValid, r_outOvf, r_outErr;
  logic [CH_W-1:0]   r_outCh;
  logic [BASE_W-1:0] r_outTemp;

  logic              w_cfgInRange, w_inInRange;
  logic [COEF_W-1:0] w_coefSel;
  logic              w_mulDone;
  logic [PROD_W-1:0] w_prod;
  logic [SUM_W-1:0]  w_sum;
  logic              w_sat;
  logic [BASE_W-1:0] w_temp;

  assign w_cfgInRange = (32'(bus.cfg_ch) < CHANNELS);
  assign w_inInRange  = (32'(bus.in_ch) < CHANNELS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        r_calBase[i] <= '0;
        r_calCoef[i] <= '0;
      end
    end else if (bus.cfg_we && w_cfgInRange) begin
      r_calBase[bus.cfg_ch] <= bus.cfg_base;
      r_calCoef[bus.cfg_ch] <= bus.cfg_coef;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid) w_stateNext = MUL;
      MUL:     if (w_mulDone) w_stateNext = ADD;
      ADD:     w_stateNext = OUT;
      OUT:     if (bus.out_ready) w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  always_comb begin
    w_inReady = 1'b0;
    w_accept  = 1'b0;
    w_load    = 1'b0;
    w_pop     = 1'b0;
    case (r_state)
      IDLE: begin
        w_inReady = 1'b1;
        w_accept  = bus.in_valid;
      end
      ADD:     w_load = 1'b1;
      OUT:     w_pop  = bus.out_ready;
      default: ;
    endcase
  end

  // Array read happens before the edge, so a same-edge cfg write is not seen.
  assign w_coefSel = w_inInRange ? r_calCoef[bus.in_ch] : '0;

  shift_add_mul #(
    .COEF_W (COEF_W),
    .SENS_W (SENS_W)
  ) u_mul (
    .clk          (clk),
    .rst          (rst),
    .start        (w_accept),
    .multiplicand (w_coefSel),
    .multiplier   (bus.in_sensor),
    .done         (w_mulDone),
    .product      (w_prod)
  );

  assign w_sum  = SUM_W'(r_base) + SUM_W'(w_prod >> FRAC_SHIFT);
  assign w_sat  = |w_sum[SUM_W-1:BASE_W];
  assign w_temp = w_sat ? '1 : w_sum[BASE_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ch       <= '0;
      r_base     <= '0;
      r_err      <= 1'b0;
      r_outValid <= 1'b0;
      r_outTemp  <= '0;
      r_outCh    <= '0;
      r_outOvf   <= 1'b0;
      r_outErr   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_ch   <= bus.in_ch;
        r_base <= w_inInRange ? r_calBase[bus.in_ch] : '0;
        r_err  <= !w_inInRange;
      end
      if (w_load) begin
        r_outValid <= 1'b1;
        r_outTemp  <= w_temp;
        r_outOvf   <= w_sat;
        r_outCh    <= r_ch;
        r_outErr   <= r_err;
      end else if (w_pop) begin
        r_outValid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_inReady;
  assign bus.out_valid = r_outValid;
  assign bus.out_temp  = r_outTemp;
  assign bus.out_ch    = r_outCh;
  assign bus.out_ovf   = r_outOvf;
  assign bus.out_err   = r_outErr;
endmodule
`default_nettype wire

// File: tb/tb_temp_calc_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_temp_calc_seq : directed bench for temp_calc_seq                |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_temp_calc_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  temp_calc_if bA ();
  temp_calc_if bB ();

  temp_calc_seq dutA (.clk(clk), .rst(rst), .bus(bA));
  temp_calc_seq #(.CHANNELS(3)) dutB (.clk(clk), .rst(rst), .bus(bB));

  int checks   = 0;
  int failures = 0;
  bit curB     = 1'b0;

  // Outputs of whichever DUT is currently selected by curB.
  logic       mV, mRdy, mOvf, mErr;
  logic [1:0] mCh;
  logic [7:0] mT;
  assign mV   = curB ? bB.out_valid : bA.out_valid;
  assign mRdy = curB ? bB.in_ready  : bA.in_ready;
  assign mOvf = curB ? bB.out_ovf   : bA.out_ovf;
  assign mErr = curB ? bB.out_err   : bA.out_err;
  assign mCh  = curB ? bB.out_ch    : bA.out_ch;
  assign mT   = curB ? bB.out_temp  : bA.out_temp;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs;
    bA.cfg_we = 0; bA.cfg_ch = 0; bA.cfg_base = 0; bA.cfg_coef = 0;
    bA.in_valid = 0; bA.in_ch = 0; bA.in_sensor = 0; bA.out_ready = 0;
    bB.cfg_we = 0; bB.cfg_ch = 0; bB.cfg_base = 0; bB.cfg_coef = 0;
    bB.in_valid = 0; bB.in_ch = 0; bB.in_sensor = 0; bB.out_ready = 0;
  endtask

  task automatic setCfg(input logic we, input logic [1:0] ch, input logic [7:0] base,
                        input logic [3:0] coef);
    if (curB) begin bB.cfg_we = we; bB.cfg_ch = ch; bB.cfg_base = base; bB.cfg_coef = coef; end
    else      begin bA.cfg_we = we; bA.cfg_ch = ch; bA.cfg_base = base; bA.cfg_coef = coef; end
  endtask

  task automatic cfgWrite(input logic [1:0] ch, input logic [7:0] base, input logic [3:0] coef);
    setCfg(1'b1, ch, base, coef);
    tick;
    setCfg(1'b0, ch, base, coef);
  endtask

  task automatic drvIn(input logic v, input logic [1:0] ch, input logic [3:0] sensor);
    if (curB) begin bB.in_valid = v; bB.in_ch = ch; bB.in_sensor = sensor; end
    else      begin bA.in_valid = v; bA.in_ch = ch; bA.in_sensor = sensor; end
  endtask

  task automatic setReady(input logic r);
    if (curB) bB.out_ready = r;
    else      bA.out_ready = r;
  endtask

  // Counts edges after the accept edge until out_valid; -1 on timeout.
  task automatic waitValid(output int lat);
    lat = -1;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      tick;
      if (mV) lat = k;
    end
  endtask

  task automatic sendWait(input logic [1:0] ch, input logic [3:0] sensor, output int lat);
    drvIn(1'b1, ch, sensor);
    tick;
    drvIn(1'b0, ch, sensor);
    waitValid(lat);
  endtask

  task automatic popResult;
    setReady(1'b1);
    tick;
    setReady(1'b0);
  endtask

  task automatic test_reset;
    int lat;
    idleInputs();
    rst = 1'b1;
    #12;
    checks++; if ({bA.out_valid, bA.out_ovf, bA.out_err} !== 3'b000) begin failures++;
      $display("FAIL reset_flags got=%b exp=000", {bA.out_valid, bA.out_ovf, bA.out_err}); end
    checks++; if (bA.in_ready !== 1'b1) begin failures++;
      $display("FAIL reset_in_ready got=%b exp=1", bA.in_ready); end
    checks++; if (bA.out_temp !== 8'd0 || bA.out_ch !== 2'd0) begin failures++;
      $display("FAIL reset_data got temp=%0d ch=%0d exp 0/0", bA.out_temp, bA.out_ch); end
    @(posedge clk); #1; rst = 1'b0;

    curB = 1'b0;
    cfgWrite(2'd1, 8'd25, 4'd5);
    sendWait(2'd1, 4'd10, lat);
    popResult();
    // Start another sample and reset it asynchronously in the middle of MUL.
    drvIn(1'b1, 2'd1, 4'd10);
    tick;
    drvIn(1'b0, 2'd1, 4'd10);
    tick; tick;
    #2 rst = 1'b1;
    #1;
    checks++; if (mV !== 1'b0 || mRdy !== 1'b1) begin failures++;
      $display("FAIL midmul_reset_hs got valid=%b ready=%b exp 0/1", mV, mRdy); end
    checks++; if (mT !== 8'd0 || mCh !== 2'd0 || mOvf !== 1'b0 || mErr !== 1'b0) begin failures++;
      $display("FAIL midmul_reset_out got temp=%0d ch=%0d ovf=%b err=%b exp all 0", mT, mCh, mOvf, mErr); end
    @(posedge clk); #1; rst = 1'b0;

    sendWait(2'd1, 4'd10, lat);
    checks++; if (mT !== 8'd0 || lat !== 5) begin failures++;
      $display("FAIL reset_cal_ch1 got temp=%0d lat=%0d exp temp=0 lat=5", mT, lat); end
    popResult();
    sendWait(2'd0, 4'd9, lat);
    checks++; if (mT !== 8'd0) begin failures++;
      $display("FAIL reset_cal_ch0 got=%0d exp=0", mT); end
    popResult();
  endtask

  task automatic test_nominal;
    int lat;
    curB = 1'b0;
    cfgWrite(2'd1, 8'd25, 4'd5);
    sendWait(2'd1, 4'd10, lat);
    checks++; if (lat !== 5) begin failures++;
      $display("FAIL nominal_latency got=%0d exp=5", lat); end
    checks++; if (mT !== 8'd31 || mOvf !== 1'b0) begin failures++;
      $display("FAIL nominal_temp got temp=%0d ovf=%b exp 31/0", mT, mOvf); end
    checks++; if (mCh !== 2'd1 || mErr !== 1'b0 || mRdy !== 1'b0) begin failures++;
      $display("FAIL nominal_meta got ch=%0d err=%b ready=%b exp 1/0/0", mCh, mErr, mRdy); end
    popResult();
    checks++; if (mV !== 1'b0 || mRdy !== 1'b1) begin failures++;
      $display("FAIL nominal_pop got valid=%b ready=%b exp 0/1", mV, mRdy); end
  endtask

  task automatic test_saturation;
    int lat;
    curB = 1'b0;
    cfgWrite(2'd2, 8'd250, 4'd15);
    sendWait(2'd2, 4'd15, lat);
    checks++; if (mT !== 8'd255 || mOvf !== 1'b1) begin failures++;
      $display("FAIL sat_over got temp=%0d ovf=%b exp 255/1", mT, mOvf); end
    popResult();
    cfgWrite(2'd2, 8'd227, 4'd15);
    sendWait(2'd2, 4'd15, lat);
    checks++; if (mT !== 8'd255 || mOvf !== 1'b0) begin failures++;
      $display("FAIL sat_edge got temp=%0d ovf=%b exp 255/0", mT, mOvf); end
    popResult();
    cfgWrite(2'd2, 8'd226, 4'd15);
    sendWait(2'd2, 4'd15, lat);
    checks++; if (mT !== 8'd254 || mOvf !== 1'b0) begin failures++;
      $display("FAIL sat_below got temp=%0d ovf=%b exp 254/0", mT, mOvf); end
    popResult();
  endtask

  task automatic test_back_to_back;
    int lat;
    curB = 1'b0;
    drvIn(1'b1, 2'd1, 4'd10);
    tick;
    drvIn(1'b1, 2'd1, 4'd3);
    waitValid(lat);
    checks++; if (lat !== 5) begin failures++;
      $display("FAIL bp_latency got=%0d exp=5", lat); end
    for (int c = 0; c < 10; c++) begin
      tick;
      checks++; if (mV !== 1'b1 || mT !== 8'd31 || mRdy !== 1'b0) begin failures++;
        $display("FAIL bp_hold cyc=%0d got valid=%b temp=%0d ready=%b exp 1/31/0", c, mV, mT, mRdy); end
    end
    setReady(1'b1);
    tick;
    setReady(1'b0);
    checks++; if (mV !== 1'b0 || mRdy !== 1'b1) begin failures++;
      $display("FAIL bp_release got valid=%b ready=%b exp 0/1", mV, mRdy); end
    tick;
    drvIn(1'b0, 2'd1, 4'd3);
    checks++; if (mRdy !== 1'b0) begin failures++;
      $display("FAIL bp_next_accept got ready=%b exp 0", mRdy); end
    waitValid(lat);
    checks++; if (lat !== 5 || mT !== 8'd26) begin failures++;
      $display("FAIL bp_second got temp=%0d lat=%0d exp 26/5", mT, lat); end
    popResult();
  endtask

  task automatic test_cfg_hazard;
    int lat;
    curB = 1'b0;
    cfgWrite(2'd3, 8'd0, 4'd7);
    setCfg(1'b1, 2'd3, 8'd0, 4'd2);
    drvIn(1'b1, 2'd3, 4'd8);
    tick;
    setCfg(1'b0, 2'd3, 8'd0, 4'd2);
    drvIn(1'b0, 2'd3, 4'd8);
    waitValid(lat);
    checks++; if (mT !== 8'd7 || lat !== 5) begin failures++;
      $display("FAIL hazard_old got temp=%0d lat=%0d exp 7/5", mT, lat); end
    popResult();
    sendWait(2'd3, 4'd8, lat);
    checks++; if (mT !== 8'd2) begin failures++;
      $display("FAIL hazard_new got=%0d exp=2", mT); end
    popResult();
  endtask

  task automatic test_out_of_range;
    int lat;
    logic [7:0] expT [3];
    expT[0] = 8'd11; expT[1] = 8'd22; expT[2] = 8'd33;
    curB = 1'b1;
    cfgWrite(2'd0, 8'd10, 4'd1);
    cfgWrite(2'd1, 8'd20, 4'd2);
    cfgWrite(2'd2, 8'd30, 4'd3);
    cfgWrite(2'd3, 8'd99, 4'd15);
    sendWait(2'd3, 4'd5, lat);
    checks++; if (mErr !== 1'b1 || mT !== 8'd0 || mOvf !== 1'b0 || mCh !== 2'd3) begin failures++;
      $display("FAIL oor_sample got err=%b temp=%0d ovf=%b ch=%0d exp 1/0/0/3", mErr, mT, mOvf, mCh); end
    popResult();
    for (int c = 0; c < 3; c++) begin
      sendWait(2'(c), 4'd8, lat);
      checks++; if (mT !== expT[c] || mErr !== 1'b0 || lat !== 5) begin failures++;
        $display("FAIL oor_keep ch=%0d got temp=%0d err=%b lat=%0d exp %0d/0/5", c, mT, mErr, lat, expT[c]); end
      popResult();
    end
    curB = 1'b0;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_saturation();
    test_back_to_back();
    test_cfg_hazard();
    test_out_of_range();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not reach summary");
    $fatal(1);
  end
endmodule
`default_nettype wire
